key_input_conditioner: RTL and testbench

KEY_INPUT_CONDITIONER -- requirements
Module: key_input_conditioner

---
 rtl/key_input_conditioner.sv | 113 +++++++++++
 tb/tb_key_input_conditioner.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/key_input_conditioner.sv
// key_input_conditioner
//   Conditions the raw, bouncing switches of a small keyboard for the
//   synthesizer: ten note keys plus pitch-up / pitch-down buttons.
//   Every raw input is synchronized (two flops), then debounced by an
//   independent counter channel. The ten debounced key bits drive `key`
//   directly; the two shift buttons step a saturating pitch-shift register
//   on their debounced rising edges.
//
// Ports
//   clk           in   system clock, all logic on rising edge
//   rst           in   synchronous active-high reset
//   key_raw       in   [9:0] raw note keys, 1 = pressed
//   shift_up_raw  in   raw pitch-up button, 1 = pressed
//   shift_dn_raw  in   raw pitch-down button, 1 = pressed
//   key           out  [9:0] debounced key vector
//   pitchshift    out  [4:0] pitch-shift setting, 0..PS_MAX
//   key_event     out  one-cycle pulse the cycle after key changes
module key_input_conditioner #(
    parameter int DB_CYCLES = 1000000,
    parameter int PS_MAX    = 24,
    parameter int PS_INIT   = 12
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] key_raw,
    input  logic       shift_up_raw,
    input  logic       shift_dn_raw,
    output logic [9:0] key,
    output logic [4:0] pitchshift,
    output logic       key_event
);

    localparam int NCH = 12;
    localparam int CW  = $clog2(DB_CYCLES + 1);
    localparam int UP  = 10;
    localparam int DN  = 11;
    // Count value on which the next differing cycle accepts the change.
    localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);
    localparam logic [4:0]    PS_TOP   = 5'(PS_MAX);
    localparam logic [4:0]    PS_RST   = 5'(PS_INIT);

    logic [NCH-1:0]         raw;
    logic [NCH-1:0]         sync1_q, sync2_q;
    logic [NCH-1:0]         db_q, db_d;
    logic [NCH-1:0][CW-1:0] cnt_q, cnt_d;
    logic                   up_prev_q, dn_prev_q;
    logic [4:0]             ps_q, ps_d;
    logic [9:0]             key_dly_q;
    logic                   key_event_q;
    logic                   up_rise, dn_rise;

    assign raw = {shift_dn_raw, shift_up_raw, key_raw};

    // Debounce channels: the counter only runs while the synchronized value
    // disagrees with the debounced state; any agreeing cycle restarts it.
    always_comb begin
        db_d  = db_q;
        cnt_d = '0;
        for (int i = 0; i < NCH; i++) begin
            if (sync2_q[i] != db_q[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    db_d[i] = sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    // Edge detectors start from 0 after reset, so a button held through
    // reset release still produces one step once it debounces.
    assign up_rise = db_q[UP] & ~up_prev_q;
    assign dn_rise = db_q[DN] & ~dn_prev_q;

    always_comb begin
        ps_d = ps_q;
        if (up_rise && !dn_rise) begin
            if (ps_q < PS_TOP) ps_d = ps_q + 5'd1;
        end else if (dn_rise && !up_rise) begin
            if (ps_q != 5'd0) ps_d = ps_q - 5'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q     <= '0;
            sync2_q     <= '0;
            db_q        <= '0;
            cnt_q       <= '0;
            up_prev_q   <= 1'b0;
            dn_prev_q   <= 1'b0;
            ps_q        <= PS_RST;
            key_dly_q   <= '0;
            key_event_q <= 1'b0;
        end else begin
            sync1_q     <= raw;
            sync2_q     <= sync1_q;
            db_q        <= db_d;
            cnt_q       <= cnt_d;
            up_prev_q   <= db_q[UP];
            dn_prev_q   <= db_q[DN];
            ps_q        <= ps_d;
            key_dly_q   <= db_q[9:0];
            // One pulse regardless of how many bits moved together.
            key_event_q <= (db_q[9:0] != key_dly_q);
        end
    end

    assign key        = db_q[9:0];
    assign pitchshift = ps_q;
    assign key_event  = key_event_q;

endmodule

// File: tb/tb_key_input_conditioner.sv
module tb_key_input_conditioner;

    localparam int DB = 4;
    localparam int K_KEY = 0, K_EVT = 1, K_PS = 2;

    typedef struct {
        int kind;
        int cyc;
        int val;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [9:0] key_raw = '0;
    logic       shift_up_raw = 1'b0;
    logic       shift_dn_raw = 1'b0;
    logic [9:0] key;
    logic [4:0] pitchshift;
    logic       key_event;

    key_input_conditioner #(.DB_CYCLES(DB), .PS_MAX(24), .PS_INIT(12)) dut (
        .clk(clk), .rst(rst), .key_raw(key_raw),
        .shift_up_raw(shift_up_raw), .shift_dn_raw(shift_dn_raw),
        .key(key), .pitchshift(pitchshift), .key_event(key_event)
    );

    always #5 clk = ~clk;

    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    exp_t q[$];
    logic [9:0] key_m = '0;
    int   ps_m = 12;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every observed output activity must match the queue head.
    logic [9:0] pk = '0;
    logic [4:0] pp = 5'd12;

    task automatic mon_check(input int kind, input int val);
        exp_t e;
        total++;
        if (q.size() == 0) begin
            bad++;
            $display("FAIL unexpected kind=%0d cyc=%0d got=%0h (no expectation)", kind, cyc, val);
        end else begin
            e = q.pop_front();
            if (e.kind != kind || e.cyc != cyc || e.val != val) begin
                bad++;
                $display("FAIL event: got kind=%0d cyc=%0d val=%0h, expected kind=%0d cyc=%0d val=%0h",
                         kind, cyc, val, e.kind, e.cyc, e.val);
            end
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (key !== pk)        mon_check(K_KEY, int'(key));
            if (key_event !== 1'b0) mon_check(K_EVT, 1);
            if (pitchshift !== pp) mon_check(K_PS, int'(pitchshift));
        end
        pk = key;
        pp = pitchshift;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int kind, input int c, input int val);
        exp_t e;
        e.kind = kind; e.cyc = c; e.val = val;
        q.push_back(e);
    endtask

    task automatic check(input string name, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
        end
    endtask

    // Drive a new key vector now; expect key after 2+DB, pulse one later.
    task automatic set_keys(input logic [9:0] v);
        key_raw = v;
        if (v != key_m) begin
            push(K_KEY, cyc + 2 + DB, int'(v));
            push(K_EVT, cyc + 3 + DB, 1);
        end
        key_m = v;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (q.size() != 0 && n < 40) begin
            tick();
            n++;
        end
        repeat (3) tick();
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL %s timeout: pending=%0d expected=0", name, q.size());
            q.delete();
        end
    endtask

    task automatic shift_press(input bit up);
        int nv;
        nv = up ? (ps_m < 24 ? ps_m + 1 : ps_m) : (ps_m > 0 ? ps_m - 1 : ps_m);
        if (up) shift_up_raw = 1'b1; else shift_dn_raw = 1'b1;
        if (nv != ps_m) push(K_PS, cyc + 3 + DB, nv);
        ps_m = nv;
        repeat (10) tick();
        shift_up_raw = 1'b0;
        shift_dn_raw = 1'b0;
        repeat (10) tick();
    endtask

    task automatic do_reset;
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        ps_m = 12;
        key_m = '0;
    endtask

    initial begin
        // Reset state
        repeat (3) tick();
        check("reset_key", int'(key), 0);
        check("reset_evt", int'(key_event), 0);
        check("reset_ps", int'(pitchshift), 12);
        rst = 1'b0;
        tick();

        // Clean press and release
        set_keys(10'h001);
        repeat (12) tick();
        set_keys(10'h000);
        drain("clean");

        // Bounce: 3 high, 1 low, then steady high; only final edge counts
        key_raw[3] = 1'b1;
        repeat (3) tick();
        key_raw[3] = 1'b0;
        tick();
        set_keys(10'h008);
        repeat (12) tick();
        set_keys(10'h000);
        drain("bounce");

        // Chord press and release, one pulse each
        set_keys(10'h2A5);
        repeat (12) tick();
        set_keys(10'h000);
        drain("chord");

        // Saturation up then down
        for (int i = 0; i < 13; i++) shift_press(1'b1);
        drain("sat_up");
        check("sat_up_ps", int'(pitchshift), 24);
        for (int i = 0; i < 30; i++) shift_press(1'b0);
        drain("sat_dn");
        check("sat_dn_ps", int'(pitchshift), 0);

        // Simultaneous up+down from 12 held 100 cycles
        do_reset();
        check("rst2_ps", int'(pitchshift), 12);
        shift_up_raw = 1'b1;
        shift_dn_raw = 1'b1;
        repeat (100) tick();
        check("simul_ps", int'(pitchshift), 12);
        shift_up_raw = 1'b0;
        shift_dn_raw = 1'b0;
        drain("simul");
        check("simul_rel_ps", int'(pitchshift), 12);

        // Reset mid-debounce, key held through reset release
        key_raw = 10'h001;
        repeat (3) tick();
        rst = 1'b1;
        tick();
        check("mid_rst_key", int'(key), 0);
        rst = 1'b0;
        key_m = 10'h001;
        push(K_KEY, cyc + 2 + DB, 1);
        push(K_EVT, cyc + 3 + DB, 1);
        repeat (2 + DB - 1) tick();
        check("mid_rst_early", int'(key), 0);
        drain("mid_rst");
        check("mid_rst_ps", int'(pitchshift), 12);
        set_keys(10'h000);
        drain("mid_rst_rel");

        // Up button held through reset release steps once
        shift_up_raw = 1'b1;
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        push(K_PS, cyc + 3 + DB, 13);
        repeat (20) tick();
        shift_up_raw = 1'b0;
        drain("held_rst_up");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
